// File: rtl/latch_bank_wr_ctrl_if.sv
// ---------------------------------------------------------------------------
// latch_bank_wr_ctrl_if
// Bundles the write handshake, clear request/status and latch-side drive
// signals of latch_bank_wr_ctrl.
//
// Optional feature macro: LATCH_WR_PARITY_EN (adds an even-parity bit on
// top of lat_d, so lat_d is DW+1 bits wide instead of DW).
//
// Handshake: a write transfers on a rising clk edge where in_valid and
// in_ready are both high; in_addr/in_data must be stable while in_valid is
// high, and in_ready may depend combinationally on clr_req.
//
// Signals
//   in_valid   requester -> ctrl   write request valid
//   in_ready   ctrl -> requester   write request can be accepted
//   in_addr    requester -> ctrl   target word index (AW bits)
//   in_data    requester -> ctrl   write data (DW bits)
//   clr_req    requester -> ctrl   bank clear request (level)
//   clr_done   ctrl -> requester   1-cycle pulse when a clear completes
//   err        ctrl -> requester   1-cycle pulse when an out-of-range write is dropped
//   busy       ctrl -> requester   controller is not idle
//   lat_d      ctrl -> latches     shared latch data (+ parity bit when enabled)
//   lat_en     ctrl -> latches     one-hot active-high latch enables (NW bits)
//   lat_rstb   ctrl -> latches     bank clear, active-low
//   state_dbg  ctrl -> observer    current FSM state encoding
// ---------------------------------------------------------------------------
interface latch_bank_wr_ctrl_if #(
    parameter int DW = 8,
    parameter int NW = 4,
    parameter int AW = 2
);
`ifdef LATCH_WR_PARITY_EN
    localparam int LDW = DW + 1;
`else
    localparam int LDW = DW;
`endif

    logic           in_valid;
    logic           in_ready;
    logic [AW-1:0]  in_addr;
    logic [DW-1:0]  in_data;
    logic           clr_req;
    logic           clr_done;
    logic           err;
    logic           busy;
    logic [LDW-1:0] lat_d;
    logic [NW-1:0]  lat_en;
    logic           lat_rstb;
    logic [2:0]     state_dbg;

    modport master (
        output in_valid, in_addr, in_data, clr_req,
        input  in_ready, clr_done, err, busy, lat_d, lat_en, lat_rstb, state_dbg
    );

    modport slave (
        input  in_valid, in_addr, in_data, clr_req,
        output in_ready, clr_done, err, busy, lat_d, lat_en, lat_rstb, state_dbg
    );
endinterface

// File: rtl/latch_bank_wr_ctrl.sv
// ---------------------------------------------------------------------------
// latch_bank_wr_ctrl
// Write sequencer for a bank of level-sensitive latches. Accepts word writes
// over a valid/ready handshake, drives the shared latch data bus and a
// one-hot enable with whole-cycle setup/open/hold windows, and sequences the
// bank-wide active-low clear.
//
// Optional feature macro: LATCH_WR_PARITY_EN. When defined, lat_d carries an
// extra MSB holding even parity (^in_data) captured with the data; it is 0
// after reset or a clear. When undefined, lat_d is exactly the data.
//
// Ports
//   clk   in   clock, all state updates on the rising edge
//   rst   in   synchronous reset, active-high
//   bus   slave modport of latch_bank_wr_ctrl_if (handshake, clear, latch drive)
//
// All outputs except in_ready are registered. in_ready is combinational so a
// clear request immediately blocks new writes.
// ---------------------------------------------------------------------------
module latch_bank_wr_ctrl #(
    parameter int DW        = 8,
    parameter int NW        = 4,
    parameter int AW        = 2,
    parameter int SETUP_CYC = 1,
    parameter int OPEN_CYC  = 1,
    parameter int HOLD_CYC  = 1,
    parameter int CLR_CYC   = 2
) (
    input logic               clk,
    input logic               rst,
    latch_bank_wr_ctrl_if.slave bus
);
`ifdef LATCH_WR_PARITY_EN
    localparam int LDW = DW + 1;
`else
    localparam int LDW = DW;
`endif

    // One down-counter serves every timed state; size it for the longest window.
    localparam int MAX_A = (SETUP_CYC > OPEN_CYC) ? SETUP_CYC : OPEN_CYC;
    localparam int MAX_B = (HOLD_CYC > CLR_CYC) ? HOLD_CYC : CLR_CYC;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_C + 1);

    // One extra bit so NW == 2**AW is representable.
    localparam logic [AW:0] NW_L = (AW+1)'(NW);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        OPEN  = 3'd2,
        HOLD  = 3'd3,
        CLR   = 3'd4
    } state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [AW-1:0]  addr_q, addr_n;
    logic [LDW-1:0] lat_d, lat_d_n;
    logic [NW-1:0]  lat_en, lat_en_n;
    logic           lat_rstb, lat_rstb_n;
    logic           err, err_n;
    logic           clr_done, clr_done_n;
    logic           clr_pend, clr_pend_n;
    logic           busy, busy_n;
    logic [LDW-1:0] cap_d;

    // Data as it will appear on the latch bus when a write is captured.
`ifdef LATCH_WR_PARITY_EN
    assign cap_d = {^bus.in_data, bus.in_data};
`else
    assign cap_d = bus.in_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            lat_d    <= '0;
            lat_en   <= '0;
            lat_rstb <= 1'b0;
            err      <= 1'b0;
            clr_done <= 1'b0;
            clr_pend <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            addr_q   <= addr_n;
            lat_d    <= lat_d_n;
            lat_en   <= lat_en_n;
            lat_rstb <= lat_rstb_n;
            err      <= err_n;
            clr_done <= clr_done_n;
            clr_pend <= clr_pend_n;
            busy     <= busy_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        addr_n     = addr_q;
        lat_d_n    = lat_d;
        lat_en_n   = '0;
        lat_rstb_n = 1'b1;
        err_n      = 1'b0;
        clr_done_n = 1'b0;
        clr_pend_n = clr_pend;

        case (state)
            IDLE: begin
                if (bus.clr_req || clr_pend) begin
                    // Clear wins over any write presented in the same cycle.
                    state_n    = CLR;
                    cnt_n      = CW'(CLR_CYC - 1);
                    lat_rstb_n = 1'b0;
                    lat_d_n    = '0;
                    clr_pend_n = 1'b0;
                end else if (bus.in_valid) begin
                    // in_ready is necessarily high on this branch.
                    if ({1'b0, bus.in_addr} >= NW_L) begin
                        err_n = 1'b1;
                    end else begin
                        state_n = SETUP;
                        cnt_n   = CW'(SETUP_CYC - 1);
                        addr_n  = bus.in_addr;
                        lat_d_n = cap_d;
                    end
                end
            end

            SETUP: begin
                if (bus.clr_req) clr_pend_n = 1'b1;
                if (cnt == '0) begin
                    state_n  = OPEN;
                    cnt_n    = CW'(OPEN_CYC - 1);
                    lat_en_n = NW'(1) << addr_q;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end

            OPEN: begin
                if (bus.clr_req) clr_pend_n = 1'b1;
                if (cnt == '0) begin
                    state_n = HOLD;
                    cnt_n   = CW'(HOLD_CYC - 1);
                end else begin
                    cnt_n    = cnt - CW'(1);
                    lat_en_n = lat_en;
                end
            end

            HOLD: begin
                if (bus.clr_req) clr_pend_n = 1'b1;
                if (cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end

            CLR: begin
                if (cnt == '0) begin
                    state_n    = IDLE;
                    clr_done_n = 1'b1;
                end else begin
                    cnt_n      = cnt - CW'(1);
                    lat_rstb_n = 1'b0;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    assign bus.in_ready  = (state == IDLE) && !bus.clr_req && !clr_pend;
    assign bus.clr_done  = clr_done;
    assign bus.err       = err;
    assign bus.busy      = busy;
    assign bus.lat_d     = lat_d;
    assign bus.lat_en    = lat_en;
    assign bus.lat_rstb  = lat_rstb;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_latch_bank_wr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_latch_bank_wr_ctrl
// Bench for latch_bank_wr_ctrl: a default NW=4 instance carries the main
// scenarios; a NW=3 instance exercises out-of-range address handling.
// Build with or without LATCH_WR_PARITY_EN.
// ---------------------------------------------------------------------------
module tb_latch_bank_wr_ctrl;
    localparam int DW = 8;
    localparam int NW = 4;
    localparam int AW = 2;
`ifdef LATCH_WR_PARITY_EN
    localparam int LDW = DW + 1;
`else
    localparam int LDW = DW;
`endif

    logic clk;
    logic rst;

    latch_bank_wr_ctrl_if #(.DW(DW), .NW(NW), .AW(AW)) bus ();
    latch_bank_wr_ctrl_if #(.DW(DW), .NW(3),  .AW(AW)) bus3 ();

    latch_bank_wr_ctrl #(.DW(DW), .NW(NW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    latch_bank_wr_ctrl #(.DW(DW), .NW(3), .AW(AW)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [LDW-1:0] model_d(input logic [DW-1:0] d);
`ifdef LATCH_WR_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    // ---------------- scoreboard ----------------
    // Entry = {expected lat_en, expected lat_d} for each enable pulse.
    logic [NW+LDW-1:0] exp_q[$];
    logic [NW+LDW-1:0] mon_e;
    int n_pulse    = 0;
    int n_done     = 0;
    int n_err_main = 0;

    always @(negedge clk) begin
        if (bus.lat_en != '0) begin
            n_pulse++;
            check("en_while_rstb_low", 32'(bus.lat_rstb), 1);
            check("en_onehot", 32'($countones(bus.lat_en)), 1);
            if (exp_q.size() == 0) begin
                check("en_unexpected", 32'(bus.lat_en), 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("en_bits", 32'(bus.lat_en), 32'(mon_e[NW+LDW-1:LDW]));
                check("en_data", 32'(bus.lat_d), 32'(mon_e[LDW-1:0]));
            end
        end
        if (bus.clr_done) n_done++;
        if (bus.err) n_err_main++;
    end

    // ---------------- driver ----------------
    task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d, output int w);
        logic [NW-1:0] en;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_addr  = a;
        bus.in_data  = d;
        w = 0;
        #1;
        while (!bus.in_ready && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!bus.in_ready) begin
            check("send_timeout", 32'(bus.in_ready), 1);
        end else begin
            en = NW'(1) << a;
            exp_q.push_back({en, model_d(d)});
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int w;
    int p0;
    int d0;

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_addr   = '0;
        bus.in_data   = '0;
        bus.clr_req   = 1'b0;
        bus3.in_valid = 1'b0;
        bus3.in_addr  = '0;
        bus3.in_data  = '0;
        bus3.clr_req  = 1'b0;

        // Reset: clear held low while in reset.
        repeat (3) begin
            @(negedge clk);
            check("rst_rstb", 32'(bus.lat_rstb), 0);
            check("rst_en", 32'(bus.lat_en), 0);
        end
        rst = 1'b0;
        #1;
        check("rst_ready", 32'(bus.in_ready), 1);
        @(negedge clk);
        check("post_rst_rstb", 32'(bus.lat_rstb), 1);
        check("post_rst_en", 32'(bus.lat_en), 0);
        check("post_rst_d", 32'(bus.lat_d), 0);
        check("post_rst_busy", 32'(bus.busy), 0);
        check("post_rst_done", 32'(bus.clr_done), 0);

        // Single write addr=2 data=A5.
        bus.in_valid = 1'b1;
        bus.in_addr  = 2'd2;
        bus.in_data  = 8'hA5;
        #1;
        check("w1_ready", 32'(bus.in_ready), 1);
        exp_q.push_back({NW'(4), model_d(8'hA5)});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("w1_setup_d", 32'(bus.lat_d), 32'(model_d(8'hA5)));
        check("w1_setup_en", 32'(bus.lat_en), 0);
        check("w1_setup_busy", 32'(bus.busy), 1);
        check("w1_setup_ready", 32'(bus.in_ready), 0);
`ifdef LATCH_WR_PARITY_EN
        check("w1_parity_a5", 32'(bus.lat_d[DW]), 0);
`endif
        @(negedge clk);
        check("w1_open_en", 32'(bus.lat_en), 4);
        @(negedge clk);
        check("w1_hold_en", 32'(bus.lat_en), 0);
        check("w1_hold_d", 32'(bus.lat_d), 32'(model_d(8'hA5)));
        @(negedge clk);
        check("w1_idle_ready", 32'(bus.in_ready), 1);
        check("w1_idle_busy", 32'(bus.busy), 0);

        // Back-to-back writes addr 0 then 3.
        p0 = n_pulse;
        send(2'd0, 8'h3C, w);
        check("b2b_first_wait", 32'(w), 0);
        send(2'd3, 8'h5A, w);
        check("b2b_second_wait", 32'(w), 3);
        repeat (5) @(negedge clk);
        check("b2b_pulses", 32'(n_pulse - p0), 2);
        check("b2b_q_empty", 32'(exp_q.size()), 0);

        // Clear requested during OPEN of a write addr=1 data=01.
        d0 = n_done;
        send(2'd1, 8'h01, w);
        @(negedge clk);
        check("cw_setup_d", 32'(bus.lat_d), 32'(model_d(8'h01)));
`ifdef LATCH_WR_PARITY_EN
        check("cw_parity_01", 32'(bus.lat_d[DW]), 1);
`endif
        @(negedge clk);
        check("cw_open_en", 32'(bus.lat_en), 2);
        bus.clr_req = 1'b1;
        @(negedge clk);
        bus.clr_req = 1'b0;
        check("cw_hold_en", 32'(bus.lat_en), 0);
        check("cw_hold_rstb", 32'(bus.lat_rstb), 1);
        check("cw_hold_d", 32'(bus.lat_d), 32'(model_d(8'h01)));
        @(negedge clk);
        #1;
        check("cw_idle_rstb", 32'(bus.lat_rstb), 1);
        check("cw_idle_ready", 32'(bus.in_ready), 0);
        @(negedge clk);
        check("cw_clr1_rstb", 32'(bus.lat_rstb), 0);
        check("cw_clr1_d", 32'(bus.lat_d), 0);
        check("cw_clr1_busy", 32'(bus.busy), 1);
        @(negedge clk);
        check("cw_clr2_rstb", 32'(bus.lat_rstb), 0);
        check("cw_clr2_done", 32'(bus.clr_done), 0);
        @(negedge clk);
        check("cw_exit_rstb", 32'(bus.lat_rstb), 1);
        check("cw_exit_done", 32'(bus.clr_done), 1);
        check("cw_exit_d", 32'(bus.lat_d), 0);
        @(negedge clk);
        check("cw_done_pulse", 32'(bus.clr_done), 0);
        check("cw_done_count", 32'(n_done - d0), 1);

        // Clear and write presented together: clear first.
        bus.clr_req  = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_addr  = 2'd2;
        bus.in_data  = 8'h77;
        #1;
        check("sim_ready_low", 32'(bus.in_ready), 0);
        @(negedge clk);
        bus.clr_req = 1'b0;
        check("sim_clr1_rstb", 32'(bus.lat_rstb), 0);
        check("sim_clr1_en", 32'(bus.lat_en), 0);
        @(negedge clk);
        check("sim_clr2_rstb", 32'(bus.lat_rstb), 0);
        @(negedge clk);
        check("sim_done", 32'(bus.clr_done), 1);
        #1;
        check("sim_ready_after", 32'(bus.in_ready), 1);
        exp_q.push_back({NW'(4), model_d(8'h77)});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("sim_q_empty", 32'(exp_q.size()), 0);

        // Level clear: two clears while clr_req stays high.
        d0 = n_done;
        bus.clr_req = 1'b1;
        repeat (6) @(negedge clk);
        bus.clr_req = 1'b0;
        repeat (2) @(negedge clk);
        check("lvl_done_count", 32'(n_done - d0), 2);
        check("lvl_idle_busy", 32'(bus.busy), 0);

        // Reset while OPEN aborts the write.
        d0 = n_done;
        send(2'd3, 8'hFF, w);
        @(negedge clk);
        @(negedge clk);
        check("rab_open_en", 32'(bus.lat_en), 8);
        rst = 1'b1;
        @(negedge clk);
        check("rab_en", 32'(bus.lat_en), 0);
        check("rab_rstb", 32'(bus.lat_rstb), 0);
        check("rab_d", 32'(bus.lat_d), 0);
        check("rab_busy", 32'(bus.busy), 0);
        rst = 1'b0;
        @(negedge clk);
        check("rab_rstb_back", 32'(bus.lat_rstb), 1);
        check("rab_no_done", 32'(n_done - d0), 0);
        check("rab_ready", 32'(bus.in_ready), 1);

        // NW=3 instance: addr 3 is out of range.
        bus3.in_valid = 1'b1;
        bus3.in_addr  = 2'd3;
        bus3.in_data  = 8'h11;
        #1;
        check("bad_ready", 32'(bus3.in_ready), 1);
        @(posedge clk);
        #1;
        bus3.in_valid = 1'b0;
        @(negedge clk);
        check("bad_err", 32'(bus3.err), 1);
        check("bad_en", 32'(bus3.lat_en), 0);
        check("bad_busy", 32'(bus3.busy), 0);
        check("bad_ready_after", 32'(bus3.in_ready), 1);
        @(negedge clk);
        check("bad_err_pulse", 32'(bus3.err), 0);
        check("bad_en2", 32'(bus3.lat_en), 0);
        bus3.in_valid = 1'b1;
        bus3.in_addr  = 2'd2;
        bus3.in_data  = 8'h22;
        #1;
        check("nw3_ready", 32'(bus3.in_ready), 1);
        @(posedge clk);
        #1;
        bus3.in_valid = 1'b0;
        @(negedge clk);
        check("nw3_no_err", 32'(bus3.err), 0);
        check("nw3_d", 32'(bus3.lat_d), 32'(model_d(8'h22)));
        @(negedge clk);
        check("nw3_en", 32'(bus3.lat_en), 4);
        @(negedge clk);
        check("nw3_en_off", 32'(bus3.lat_en), 0);

        // Final scoreboard state.
        repeat (2) @(negedge clk);
        check("main_err_never", 32'(n_err_main), 0);
        check("final_q_empty", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
